bsg_nonsynth_axi4_mem_lat: RTL and testbench

// Non-synthesizable AXI4 slave memory model for cosim benches; successor to the fixed-timing axi mem model.

---
 rtl/bsg_axi4_mem_pkg.sv | 36 +++
 rtl/bsg_axi4_burst_addr_gen.sv | 40 ++++
 rtl/bsg_nonsynth_axi4_mem_lat.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_bsg_nonsynth_axi4_mem_lat.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_axi4_mem_pkg.sv
// Shared types for the latency-programmable AXI4 slave memory model.
// Burst encodings, response codes, channel FSM states and the burst control word.
package bsg_axi4_mem_pkg;

    typedef enum logic [1:0] {
        e_burst_fixed = 2'd0,
        e_burst_incr  = 2'd1,
        e_burst_wrap  = 2'd2,
        e_burst_rsvd  = 2'd3
    } axi_burst_e;

    localparam logic [1:0] axi_resp_okay_gp   = 2'b00;
    localparam logic [1:0] axi_resp_slverr_gp = 2'b10;

    typedef enum logic [1:0] {
        e_w_idle = 2'd0,
        e_w_data = 2'd1,
        e_w_lat  = 2'd2,
        e_w_resp = 2'd3
    } wr_state_e;

    typedef enum logic [1:0] {
        e_r_idle = 2'd0,
        e_r_lat  = 2'd1,
        e_r_data = 2'd2
    } rd_state_e;

    // Width-independent part of a burst descriptor; id/addr are added per instance.
    typedef struct packed {
        logic [7:0] len;
        logic [2:0] size;
        axi_burst_e burst;
        logic       err;
    } burst_ctl_s;

endpackage

// File: rtl/bsg_axi4_burst_addr_gen.sv
// Combinational AXI4 next-beat address generator with burst legality check.
// Shared by the AW and AR sides of the memory model.
module bsg_axi4_burst_addr_gen
    import bsg_axi4_mem_pkg::*;
#(
    parameter int addr_width_p    = 32,
    parameter int lg_data_bytes_p = 3
) (
    input  logic [addr_width_p-1:0] addr_i,
    input  logic [7:0]              len_i,
    input  logic [2:0]              size_i,
    input  axi_burst_e              burst_i,
    output logic [addr_width_p-1:0] next_addr_o,
    output logic                    illegal_o
);

    logic [addr_width_p-1:0] size_bytes;
    logic [addr_width_p-1:0] wrap_mask;
    logic [addr_width_p-1:0] incr_addr;
    logic                    wrap_len_ok;

    always_comb begin
        size_bytes  = addr_width_p'(1) << size_i;
        wrap_mask   = ((addr_width_p'(len_i) + addr_width_p'(1)) << size_i) - addr_width_p'(1);
        incr_addr   = addr_i + size_bytes;
        wrap_len_ok = (len_i == 8'd1) || (len_i == 8'd3) || (len_i == 8'd7) || (len_i == 8'd15);

        illegal_o = (int'(size_i) > lg_data_bytes_p)
                  || (burst_i == e_burst_rsvd)
                  || ((burst_i == e_burst_wrap) && !wrap_len_ok);

        case (burst_i)
            // INCR aligns to the transfer size so an unaligned start only affects beat 0.
            e_burst_incr: next_addr_o = (addr_i & ~(size_bytes - addr_width_p'(1))) + size_bytes;
            e_burst_wrap: next_addr_o = (addr_i & ~wrap_mask) | (incr_addr & wrap_mask);
            default:      next_addr_o = addr_i;
        endcase
    end

endmodule

// File: rtl/bsg_nonsynth_axi4_mem_lat.sv
// AXI4 slave memory model with FIXED/INCR/WRAP bursts, narrow writes and programmable latency.
// Read and write channels are independent FSMs, each with one burst in flight.
module bsg_nonsynth_axi4_mem_lat
    import bsg_axi4_mem_pkg::*;
#(
    parameter int axi_id_width_p   = 6,
    parameter int axi_addr_width_p = 32,
    parameter int axi_data_width_p = 64,
    parameter int mem_els_p        = 2**20,
    parameter int rd_lat_p         = 4,
    parameter int wr_lat_p         = 2,
    parameter logic [axi_data_width_p-1:0] init_data_p = '0
) (
    input  logic                          clk_i,
    input  logic                          reset_i,

    input  logic [axi_id_width_p-1:0]     axi_awid_i,
    input  logic [axi_addr_width_p-1:0]   axi_awaddr_i,
    input  logic [7:0]                    axi_awlen_i,
    input  logic [2:0]                    axi_awsize_i,
    input  logic [1:0]                    axi_awburst_i,
    input  logic                          axi_awvalid_i,
    output logic                          axi_awready_o,

    input  logic [axi_data_width_p-1:0]   axi_wdata_i,
    input  logic [axi_data_width_p/8-1:0] axi_wstrb_i,
    input  logic                          axi_wlast_i,
    input  logic                          axi_wvalid_i,
    output logic                          axi_wready_o,

    output logic [axi_id_width_p-1:0]     axi_bid_o,
    output logic [1:0]                    axi_bresp_o,
    output logic                          axi_bvalid_o,
    input  logic                          axi_bready_i,

    input  logic [axi_id_width_p-1:0]     axi_arid_i,
    input  logic [axi_addr_width_p-1:0]   axi_araddr_i,
    input  logic [7:0]                    axi_arlen_i,
    input  logic [2:0]                    axi_arsize_i,
    input  logic [1:0]                    axi_arburst_i,
    input  logic                          axi_arvalid_i,
    output logic                          axi_arready_o,

    output logic [axi_id_width_p-1:0]     axi_rid_o,
    output logic [axi_data_width_p-1:0]   axi_rdata_o,
    output logic [1:0]                    axi_rresp_o,
    output logic                          axi_rlast_o,
    output logic                          axi_rvalid_o,
    input  logic                          axi_rready_i,

    output wr_state_e                     dbg_wr_state_o,
    output rd_state_e                     dbg_rd_state_o
);

    // Handshakes: a beat transfers on a rising clk edge where valid & ready are both high.
    // Readies depend only on FSM state, never on the partner's valid; R/B payloads hold until taken.

    localparam int data_bytes_lp    = axi_data_width_p / 8;
    localparam int lg_data_bytes_lp = $clog2(data_bytes_lp);
    localparam int max_lat_lp       = (rd_lat_p > wr_lat_p) ? rd_lat_p : wr_lat_p;
    localparam int lat_width_lp     = (max_lat_lp > 0) ? $clog2(max_lat_lp + 1) : 1;
    localparam int mem_idx_width_lp = (mem_els_p > 1) ? $clog2(mem_els_p) : 1;

    typedef logic [lat_width_lp-1:0] lat_t;
    typedef struct packed {
        logic [axi_id_width_p-1:0]   id;
        logic [axi_addr_width_p-1:0] addr;
        burst_ctl_s                  ctl;
    } burst_desc_s;

    logic [axi_data_width_p-1:0] mem_r [mem_els_p] = '{default: init_data_p};

    function automatic logic in_range(input logic [axi_addr_width_p-1:0] a);
        return (a >> lg_data_bytes_lp) < axi_addr_width_p'(mem_els_p);
    endfunction

    function automatic logic [mem_idx_width_lp-1:0] word_idx(input logic [axi_addr_width_p-1:0] a);
        return mem_idx_width_lp'(a >> lg_data_bytes_lp);
    endfunction

    // ---------------- write channel ----------------
    wr_state_e                   w_state_r, w_state_n;
    burst_desc_s                 aw_r;
    logic [7:0]                  w_cnt_r;
    logic                        w_slverr_r;
    lat_t                        w_lat_r;
    logic                        aw_hs, w_hs, b_hs;
    logic [axi_addr_width_p-1:0] aw_gen_addr, aw_next_addr;
    logic [7:0]                  aw_gen_len;
    logic [2:0]                  aw_gen_size;
    axi_burst_e                  aw_gen_burst;
    logic                        aw_illegal;

    assign aw_hs = axi_awvalid_i & axi_awready_o;
    assign w_hs  = axi_wvalid_i & axi_wready_o;
    assign b_hs  = axi_bvalid_o & axi_bready_i;

    // In idle the generator judges the incoming request; otherwise it advances the live burst.
    always_comb begin
        if (w_state_r == e_w_idle) begin
            aw_gen_addr  = axi_awaddr_i;
            aw_gen_len   = axi_awlen_i;
            aw_gen_size  = axi_awsize_i;
            aw_gen_burst = axi_burst_e'(axi_awburst_i);
        end else begin
            aw_gen_addr  = aw_r.addr;
            aw_gen_len   = aw_r.ctl.len;
            aw_gen_size  = aw_r.ctl.size;
            aw_gen_burst = aw_r.ctl.burst;
        end
    end

    bsg_axi4_burst_addr_gen #(
        .addr_width_p   (axi_addr_width_p),
        .lg_data_bytes_p(lg_data_bytes_lp)
    ) aw_gen (
        .addr_i     (aw_gen_addr),
        .len_i      (aw_gen_len),
        .size_i     (aw_gen_size),
        .burst_i    (aw_gen_burst),
        .next_addr_o(aw_next_addr),
        .illegal_o  (aw_illegal)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) w_state_r <= e_w_idle;
        else         w_state_r <= w_state_n;
    end

    always_comb begin
        w_state_n = w_state_r;
        case (w_state_r)
            e_w_idle: if (aw_hs) w_state_n = e_w_data;
            e_w_data: if (w_hs && axi_wlast_i) w_state_n = (wr_lat_p == 0) ? e_w_resp : e_w_lat;
            e_w_lat:  if (w_lat_r == '0) w_state_n = e_w_resp;
            e_w_resp: if (b_hs) w_state_n = e_w_idle;
            default:  w_state_n = e_w_idle;
        endcase
    end

    always_comb begin
        axi_awready_o  = (w_state_r == e_w_idle);
        axi_wready_o   = (w_state_r == e_w_data);
        axi_bvalid_o   = (w_state_r == e_w_resp);
        axi_bid_o      = axi_bvalid_o ? aw_r.id : '0;
        axi_bresp_o    = (axi_bvalid_o && (w_slverr_r || aw_r.ctl.err)) ? axi_resp_slverr_gp
                                                                        : axi_resp_okay_gp;
        dbg_wr_state_o = w_state_r;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            aw_r       <= '0;
            w_cnt_r    <= '0;
            w_slverr_r <= 1'b0;
            w_lat_r    <= '0;
        end else begin
            if (aw_hs) begin
                aw_r.id        <= axi_awid_i;
                aw_r.addr      <= axi_awaddr_i;
                aw_r.ctl.len   <= axi_awlen_i;
                aw_r.ctl.size  <= axi_awsize_i;
                aw_r.ctl.burst <= axi_burst_e'(axi_awburst_i);
                aw_r.ctl.err   <= aw_illegal;
                w_cnt_r        <= '0;
                w_slverr_r     <= 1'b0;
            end
            if (w_hs) begin
                aw_r.addr <= aw_next_addr;
                w_cnt_r   <= w_cnt_r + 8'd1;
                // wlast must coincide exactly with beat awlen+1; either mismatch poisons the burst.
                if ((axi_wlast_i != (w_cnt_r == aw_r.ctl.len)) || !in_range(aw_r.addr))
                    w_slverr_r <= 1'b1;
                if (axi_wlast_i) w_lat_r <= lat_t'(wr_lat_p - 1);
            end
            if ((w_state_r == e_w_lat) && (w_lat_r != '0)) w_lat_r <= w_lat_r - lat_t'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i && w_hs && !aw_r.ctl.err && in_range(aw_r.addr)) begin
            for (int b = 0; b < data_bytes_lp; b++) begin
                if (axi_wstrb_i[b]) mem_r[word_idx(aw_r.addr)][8*b +: 8] <= axi_wdata_i[8*b +: 8];
            end
        end
    end

    // ---------------- read channel ----------------
    rd_state_e                   r_state_r, r_state_n;
    burst_desc_s                 ar_r;
    logic [7:0]                  r_cnt_r;
    lat_t                        r_lat_r;
    logic [axi_data_width_p-1:0] r_data_r;
    logic                        r_slverr_r;
    logic                        ar_hs, r_hs, r_last_beat;
    logic                        r_fetch, r_fetch_err;
    logic [axi_addr_width_p-1:0] r_fetch_addr;
    logic [axi_addr_width_p-1:0] ar_gen_addr, ar_next_addr;
    logic [7:0]                  ar_gen_len;
    logic [2:0]                  ar_gen_size;
    axi_burst_e                  ar_gen_burst;
    logic                        ar_illegal;

    assign ar_hs       = axi_arvalid_i & axi_arready_o;
    assign r_hs        = axi_rvalid_o & axi_rready_i;
    assign r_last_beat = (r_cnt_r == ar_r.ctl.len);

    always_comb begin
        if (r_state_r == e_r_idle) begin
            ar_gen_addr  = axi_araddr_i;
            ar_gen_len   = axi_arlen_i;
            ar_gen_size  = axi_arsize_i;
            ar_gen_burst = axi_burst_e'(axi_arburst_i);
        end else begin
            ar_gen_addr  = ar_r.addr;
            ar_gen_len   = ar_r.ctl.len;
            ar_gen_size  = ar_r.ctl.size;
            ar_gen_burst = ar_r.ctl.burst;
        end
    end

    bsg_axi4_burst_addr_gen #(
        .addr_width_p   (axi_addr_width_p),
        .lg_data_bytes_p(lg_data_bytes_lp)
    ) ar_gen (
        .addr_i     (ar_gen_addr),
        .len_i      (ar_gen_len),
        .size_i     (ar_gen_size),
        .burst_i    (ar_gen_burst),
        .next_addr_o(ar_next_addr),
        .illegal_o  (ar_illegal)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) r_state_r <= e_r_idle;
        else         r_state_r <= r_state_n;
    end

    always_comb begin
        r_state_n = r_state_r;
        case (r_state_r)
            e_r_idle: if (ar_hs) r_state_n = (rd_lat_p == 0) ? e_r_data : e_r_lat;
            e_r_lat:  if (r_lat_r == '0) r_state_n = e_r_data;
            e_r_data: if (r_hs && r_last_beat) r_state_n = e_r_idle;
            default:  r_state_n = e_r_idle;
        endcase
    end

    always_comb begin
        axi_arready_o  = (r_state_r == e_r_idle);
        axi_rvalid_o   = (r_state_r == e_r_data);
        axi_rid_o      = axi_rvalid_o ? ar_r.id : '0;
        axi_rdata_o    = axi_rvalid_o ? r_data_r : '0;
        axi_rresp_o    = (axi_rvalid_o && r_slverr_r) ? axi_resp_slverr_gp : axi_resp_okay_gp;
        axi_rlast_o    = axi_rvalid_o && r_last_beat;
        dbg_rd_state_o = r_state_r;
    end

    // Beat data is registered when a beat is presented so it stays stable under backpressure.
    always_comb begin
        r_fetch      = 1'b0;
        r_fetch_addr = ar_r.addr;
        r_fetch_err  = ar_r.ctl.err;
        case (r_state_r)
            e_r_idle: if (ar_hs && (rd_lat_p == 0)) begin
                r_fetch      = 1'b1;
                r_fetch_addr = axi_araddr_i;
                r_fetch_err  = ar_illegal;
            end
            e_r_lat:  r_fetch = (r_lat_r == '0);
            e_r_data: if (r_hs && !r_last_beat) begin
                r_fetch      = 1'b1;
                r_fetch_addr = ar_next_addr;
            end
            default: r_fetch = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ar_r       <= '0;
            r_cnt_r    <= '0;
            r_lat_r    <= '0;
            r_data_r   <= '0;
            r_slverr_r <= 1'b0;
        end else begin
            if (ar_hs) begin
                ar_r.id        <= axi_arid_i;
                ar_r.addr      <= axi_araddr_i;
                ar_r.ctl.len   <= axi_arlen_i;
                ar_r.ctl.size  <= axi_arsize_i;
                ar_r.ctl.burst <= axi_burst_e'(axi_arburst_i);
                ar_r.ctl.err   <= ar_illegal;
                r_cnt_r        <= '0;
                r_lat_r        <= lat_t'(rd_lat_p - 1);
            end
            if ((r_state_r == e_r_lat) && (r_lat_r != '0)) r_lat_r <= r_lat_r - lat_t'(1);
            if (r_hs) begin
                r_cnt_r   <= r_cnt_r + 8'd1;
                ar_r.addr <= ar_next_addr;
            end
            if (r_fetch) begin
                if (r_fetch_err || !in_range(r_fetch_addr)) begin
                    r_data_r   <= '0;
                    r_slverr_r <= 1'b1;
                end else begin
                    r_data_r   <= mem_r[word_idx(r_fetch_addr)];
                    r_slverr_r <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_bsg_nonsynth_axi4_mem_lat.sv
// Directed self-checking bench for bsg_nonsynth_axi4_mem_lat (1024-word memory, rd_lat 4, wr_lat 2).
module tb_bsg_nonsynth_axi4_mem_lat;
    import bsg_axi4_mem_pkg::*;

    localparam int id_w   = 6;
    localparam int addr_w = 32;
    localparam int data_w = 64;
    localparam int rd_lat = 4;
    localparam int wr_lat = 2;
    localparam logic [1:0] okay   = 2'b00;
    localparam logic [1:0] slverr = 2'b10;
    localparam logic [1:0] b_fixed = 2'd0, b_incr = 2'd1, b_wrap = 2'd2, b_rsvd = 2'd3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [id_w-1:0]     awid, arid, bid, rid;
    logic [addr_w-1:0]   awaddr, araddr;
    logic [7:0]          awlen, arlen;
    logic [2:0]          awsize, arsize;
    logic [1:0]          awburst, arburst, bresp, rresp;
    logic                awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic                arvalid, arready, rlast, rvalid, rready;
    logic [data_w-1:0]   wdata, rdata;
    logic [data_w/8-1:0] wstrb;
    wr_state_e           wr_state;
    rd_state_e           rd_state;

    bsg_nonsynth_axi4_mem_lat #(
        .axi_id_width_p(id_w), .axi_addr_width_p(addr_w), .axi_data_width_p(data_w),
        .mem_els_p(1024), .rd_lat_p(rd_lat), .wr_lat_p(wr_lat), .init_data_p('0)
    ) dut (
        .clk_i(clk), .reset_i(reset),
        .axi_awid_i(awid), .axi_awaddr_i(awaddr), .axi_awlen_i(awlen), .axi_awsize_i(awsize),
        .axi_awburst_i(awburst), .axi_awvalid_i(awvalid), .axi_awready_o(awready),
        .axi_wdata_i(wdata), .axi_wstrb_i(wstrb), .axi_wlast_i(wlast), .axi_wvalid_i(wvalid),
        .axi_wready_o(wready),
        .axi_bid_o(bid), .axi_bresp_o(bresp), .axi_bvalid_o(bvalid), .axi_bready_i(bready),
        .axi_arid_i(arid), .axi_araddr_i(araddr), .axi_arlen_i(arlen), .axi_arsize_i(arsize),
        .axi_arburst_i(arburst), .axi_arvalid_i(arvalid), .axi_arready_o(arready),
        .axi_rid_o(rid), .axi_rdata_o(rdata), .axi_rresp_o(rresp), .axi_rlast_o(rlast),
        .axi_rvalid_o(rvalid), .axi_rready_i(rready),
        .dbg_wr_state_o(wr_state), .dbg_rd_state_o(rd_state)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [data_w-1:0] exp_q[$];
    logic [1:0]        exp_resp_q[$];
    logic [data_w-1:0] wdat_q[$];
    logic [7:0]        wstrb_q[$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_beat(input logic [data_w-1:0] d, input logic [1:0] r);
        exp_q.push_back(d);
        exp_resp_q.push_back(r);
    endtask

    // ---------------- driver tasks ----------------
    task automatic axi_write(input string name, input logic [id_w-1:0] id, input logic [addr_w-1:0] addr,
                             input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                             input logic [1:0] exp_resp);
        int cyc;
        int n;
        n = wdat_q.size();
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        cyc = 0;
        while (!awready && cyc < 50) begin @(posedge clk); #1; cyc++; end
        if (cyc == 50) check_val({name, ".aw_timeout"}, awready, 1'b1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int i = 0; i < n; i++) begin
            wdata = wdat_q[i]; wstrb = wstrb_q[i]; wlast = (i == n - 1); wvalid = 1'b1;
            cyc = 0;
            while (!wready && cyc < 50) begin @(posedge clk); #1; cyc++; end
            if (cyc == 50) check_val({name, ".w_timeout"}, wready, 1'b1);
            @(posedge clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        bready = 1'b1;
        cyc = 1;
        while (!bvalid && cyc < 50) begin @(posedge clk); #1; cyc++; end
        check_val({name, ".b_lat"}, cyc, wr_lat + 1);
        check_val({name, ".bresp"}, bresp, exp_resp);
        check_val({name, ".bid"}, bid, id);
        @(posedge clk); #1;
        bready = 1'b0;
        check_val({name, ".awready_after"}, awready, 1'b1);
        wdat_q.delete();
        wstrb_q.delete();
    endtask

    task automatic axi_read(input string name, input logic [id_w-1:0] id, input logic [addr_w-1:0] addr,
                            input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                            input int stall_beat);
        int cyc;
        logic [data_w-1:0] e;
        logic [1:0] er;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        rready = 1'b1;
        cyc = 0;
        while (!arready && cyc < 50) begin @(posedge clk); #1; cyc++; end
        if (cyc == 50) check_val({name, ".ar_timeout"}, arready, 1'b1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        cyc = 1;
        while (!rvalid && cyc < 50) begin @(posedge clk); #1; cyc++; end
        check_val({name, ".first_lat"}, cyc, rd_lat + 1);
        for (int beat = 0; beat <= int'(len); beat++) begin
            e  = exp_q.pop_front();
            er = exp_resp_q.pop_front();
            cyc = 0;
            while (!rvalid && cyc < 50) begin @(posedge clk); #1; cyc++; end
            if (cyc == 50) check_val($sformatf("%s.rvalid%0d", name, beat), rvalid, 1'b1);
            if (beat == stall_beat) begin
                rready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    @(posedge clk); #1;
                    check_val($sformatf("%s.stall_valid%0d", name, s), rvalid, 1'b1);
                    check_val($sformatf("%s.stall_data%0d", name, s), rdata, e);
                    check_val($sformatf("%s.stall_last%0d", name, s), rlast, beat == int'(len));
                end
                rready = 1'b1;
            end
            check_val($sformatf("%s.rdata%0d", name, beat), rdata, e);
            check_val($sformatf("%s.rresp%0d", name, beat), rresp, er);
            check_val($sformatf("%s.rlast%0d", name, beat), rlast, beat == int'(len));
            check_val($sformatf("%s.rid%0d", name, beat), rid, id);
            @(posedge clk); #1;
        end
        rready = 1'b0;
        check_val({name, ".arready_after"}, arready, 1'b1);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int cyc;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_val("rst.awready", awready, 1'b1);
        check_val("rst.arready", arready, 1'b1);
        check_val("rst.wready", wready, 1'b0);
        check_val("rst.bvalid", bvalid, 1'b0);
        check_val("rst.rvalid", rvalid, 1'b0);
        check_val("rst.rlast", rlast, 1'b0);
        check_val("rst.bresp", bresp, 2'b00);
        check_val("rst.rresp", rresp, 2'b00);
        check_val("rst.bid", bid, '0);
        check_val("rst.rid", rid, '0);
        check_val("rst.wr_state", wr_state, e_w_idle);
        check_val("rst.rd_state", rd_state, e_r_idle);
        reset = 1'b0;

        // INCR write then read back, with backpressure on the second beat
        for (int i = 0; i < 4; i++) begin wdat_q.push_back(64'hA0 + i); wstrb_q.push_back(8'hFF); end
        axi_write("incr_wr", 6'd5, 32'h100, 8'd3, 3'd3, b_incr, okay);
        for (int i = 0; i < 4; i++) expect_beat(64'hA0 + i, okay);
        axi_read("incr_rd", 6'd9, 32'h100, 8'd3, 3'd3, b_incr, 1);

        // WRAP from the top of a 32-byte window, then FIXED on the same word
        expect_beat(64'hA3, okay); expect_beat(64'hA0, okay);
        expect_beat(64'hA1, okay); expect_beat(64'hA2, okay);
        axi_read("wrap_rd", 6'd10, 32'h118, 8'd3, 3'd3, b_wrap, -1);
        for (int i = 0; i < 4; i++) expect_beat(64'hA3, okay);
        axi_read("fixed_rd", 6'd11, 32'h118, 8'd3, 3'd3, b_fixed, -1);

        // Narrow single-byte write: only lane 1 may change
        wdat_q.push_back(64'hDEAD_BEEF_CAFE_FF00); wstrb_q.push_back(8'h02);
        axi_write("narrow_wr", 6'd1, 32'h101, 8'd0, 3'd0, b_incr, okay);
        expect_beat(64'h0000_0000_0000_FFA0, okay);
        axi_read("narrow_rd", 6'd2, 32'h100, 8'd0, 3'd3, b_incr, -1);

        // Burst straddling the end of memory: first beat lands, second is dropped
        wdat_q.push_back(64'h1234); wstrb_q.push_back(8'hFF);
        wdat_q.push_back(64'h5678); wstrb_q.push_back(8'hFF);
        axi_write("edge_wr", 6'd3, 32'h1FF8, 8'd1, 3'd3, b_incr, slverr);
        expect_beat(64'h1234, okay); expect_beat(64'h0, slverr);
        axi_read("edge_rd", 6'd4, 32'h1FF8, 8'd1, 3'd3, b_incr, -1);

        wdat_q.push_back(64'h77); wstrb_q.push_back(8'hFF);
        wdat_q.push_back(64'h88); wstrb_q.push_back(8'hFF);
        axi_write("oor_wr", 6'd6, 32'h2000, 8'd1, 3'd3, b_incr, slverr);
        expect_beat(64'h0, slverr);
        axi_read("oor_rd", 6'd7, 32'h2000, 8'd0, 3'd3, b_incr, -1);

        // Early wlast on beat 2 of 4: SLVERR, but both beats persist
        wdat_q.push_back(64'hB0); wstrb_q.push_back(8'hFF);
        wdat_q.push_back(64'hB1); wstrb_q.push_back(8'hFF);
        axi_write("early_wr", 6'd8, 32'h140, 8'd3, 3'd3, b_incr, slverr);
        expect_beat(64'hB0, okay); expect_beat(64'hB1, okay);
        axi_read("early_rd", 6'd12, 32'h140, 8'd1, 3'd3, b_incr, -1);

        // wlast missing on beat awlen+1
        wdat_q.push_back(64'hC0); wstrb_q.push_back(8'hFF);
        wdat_q.push_back(64'hC1); wstrb_q.push_back(8'hFF);
        axi_write("late_wr", 6'd13, 32'h1C0, 8'd0, 3'd3, b_incr, slverr);

        // Illegal bursts: reserved type writes nothing, oversize and bad WRAP length read zeros
        wdat_q.push_back(64'h55); wstrb_q.push_back(8'hFF);
        axi_write("rsvd_wr", 6'd14, 32'h180, 8'd0, 3'd3, b_rsvd, slverr);
        expect_beat(64'h0, okay);
        axi_read("rsvd_chk", 6'd15, 32'h180, 8'd0, 3'd3, b_incr, -1);
        expect_beat(64'h0, slverr);
        axi_read("size_rd", 6'd16, 32'h100, 8'd0, 3'd4, b_incr, -1);
        for (int i = 0; i < 3; i++) expect_beat(64'h0, slverr);
        axi_read("wraplen_rd", 6'd17, 32'h100, 8'd2, 3'd3, b_wrap, -1);

        // Reset on beat 2 of a 4-beat read
        arid = 6'd20; araddr = 32'h100; arlen = 8'd3; arsize = 3'd3; arburst = b_incr; arvalid = 1'b1;
        rready = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        cyc = 0;
        while (!rvalid && cyc < 50) begin @(posedge clk); #1; cyc++; end
        check_val("mid_rst.beat1", rdata, 64'hFFA0);
        @(posedge clk); #1;
        check_val("mid_rst.beat2", rdata, 64'hA1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        rready = 1'b0;
        check_val("mid_rst.rvalid", rvalid, 1'b0);
        check_val("mid_rst.arready", arready, 1'b1);
        check_val("mid_rst.rlast", rlast, 1'b0);
        check_val("mid_rst.rresp", rresp, 2'b00);
        expect_beat(64'hA1, okay);
        axi_read("post_rst", 6'd21, 32'h108, 8'd0, 3'd3, b_incr, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
